// File: rtl/zstd_frame_header_parser_p.sv
// Zstandard frame header parser, IN_BYTES bytes per input beat.
// Validates the magic (including skippable frames), decodes the Frame_Header_Descriptor,
// assembles Window_Descriptor / Dictionary_ID / Frame_Content_Size little-endian and hands
// the header plus any trailing payload bytes of the final beat to the block decoder.
module zstd_frame_header_parser_p #(
   parameter int unsigned IN_BYTES       = 4,
   parameter bit          CHECK_RESERVED = 1'b1,
   parameter int unsigned CNT_W          = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*IN_BYTES-1:0] in_data,
   output logic                  hdr_valid,
   input  logic                  hdr_ready,
   output logic                  skippable,
   output logic [31:0]           skip_size,
   output logic [7:0]            fhd,
   output logic [7:0]            window_desc,
   output logic [31:0]           dict_id,
   output logic [63:0]           fcs,
   output logic                  checksum_flag,
   output logic [7:0]            sizes,
   output logic [8*IN_BYTES-1:0] rem_data,
   output logic [3:0]            rem_count,
   output logic                  err_valid,
   output logic [1:0]            err_code
);

   localparam logic [31:0] ZstdMagic   = 32'hFD2FB528;
   localparam logic [27:0] SkipMagicHi = 28'h184D2A5;
   localparam logic [1:0]  ErrNone     = 2'd0;
   localparam logic [1:0]  ErrBadMagic = 2'd1;
   localparam logic [1:0]  ErrReserved = 2'd2;

   typedef enum logic [1:0] {StCollect, StDone, StError} state_e;

   // Field byte counts implied by a descriptor.
   function automatic int fhd_wd(input logic [7:0] f);
      return f[5] ? 0 : 1;
   endfunction

   function automatic int fhd_did(input logic [7:0] f);
      case (f[1:0])
         2'd0:    return 0;
         2'd1:    return 1;
         2'd2:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int fhd_fcs(input logic [7:0] f);
      case (f[7:6])
         2'd0:    return f[5] ? 1 : 0;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 8;
      endcase
   endfunction

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [31:0]           magic_q, magic_d;
   logic                  skip_q, skip_d;
   logic [4:0]            target_q, target_d;
   logic [31:0]           skip_size_q, skip_size_d;
   logic [7:0]            fhd_q, fhd_d;
   logic [7:0]            wd_q, wd_d;
   logic [31:0]           did_q, did_d;
   logic [63:0]           fcs_q, fcs_d;
   logic [8*IN_BYTES-1:0] rem_data_q, rem_data_d;
   logic [3:0]            rem_count_q, rem_count_d;
   logic [1:0]            err_code_q, err_code_d;

   logic       hit_done, hit_err, wipe;
   logic [7:0] cur_byte;
   int         n, o, rem_idx, t_wd, t_did;

   // Next-state: walk every byte of an accepted beat in stream order.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      magic_d     = magic_q;
      skip_d      = skip_q;
      target_d    = target_q;
      skip_size_d = skip_size_q;
      fhd_d       = fhd_q;
      wd_d        = wd_q;
      did_d       = did_q;
      fcs_d       = fcs_q;
      rem_data_d  = rem_data_q;
      rem_count_d = rem_count_q;
      err_code_d  = err_code_q;
      hit_done    = 1'b0;
      hit_err     = 1'b0;
      wipe        = 1'b0;
      cur_byte    = 8'h00;
      n           = 0;
      o           = 0;
      rem_idx     = 0;
      t_wd        = 0;
      t_did       = 0;

      case (state_q)
         StCollect: begin
            if (in_valid) begin
               rem_data_d = '0;
               for (int k = 0; k < int'(IN_BYTES); k++) begin
                  cur_byte = in_data[8*k +: 8];
                  n        = int'(count_q) + k;
                  if (hit_done) begin
                     // Payload that shared the last header beat.
                     for (int j = 0; j < int'(IN_BYTES); j++) begin
                        if (rem_idx == j) rem_data_d[8*j +: 8] = cur_byte;
                     end
                     rem_idx = rem_idx + 1;
                  end else if (!hit_err) begin
                     if (n < 4) begin
                        for (int j = 0; j < 4; j++) begin
                           if (n == j) magic_d[8*j +: 8] = cur_byte;
                        end
                        if (n == 3) begin
                           if (magic_d[31:4] == SkipMagicHi) begin
                              skip_d   = 1'b1;
                              target_d = 5'd8;
                           end else if (magic_d != ZstdMagic) begin
                              hit_err    = 1'b1;
                              err_code_d = ErrBadMagic;
                           end
                        end
                     end else if (skip_d) begin
                        for (int j = 0; j < 4; j++) begin
                           if (n == 4 + j) skip_size_d[8*j +: 8] = cur_byte;
                        end
                     end else if (n == 4) begin
                        fhd_d    = cur_byte;
                        target_d = 5'(5 + fhd_wd(cur_byte) + fhd_did(cur_byte)
                                   + fhd_fcs(cur_byte));
                        if (CHECK_RESERVED && cur_byte[3]) begin
                           hit_err    = 1'b1;
                           err_code_d = ErrReserved;
                        end
                     end else begin
                        // Optional fields follow the descriptor in WD, DID, FCS order.
                        o     = n - 5;
                        t_wd  = fhd_wd(fhd_d);
                        t_did = fhd_did(fhd_d);
                        if (o < t_wd) begin
                           wd_d = cur_byte;
                        end else if (o < t_wd + t_did) begin
                           for (int j = 0; j < 4; j++) begin
                              if (o - t_wd == j) did_d[8*j +: 8] = cur_byte;
                           end
                        end else begin
                           for (int j = 0; j < 8; j++) begin
                              if (o - t_wd - t_did == j) fcs_d[8*j +: 8] = cur_byte;
                           end
                        end
                     end
                     if (!hit_err && n >= 4 && n == int'(target_d) - 1) hit_done = 1'b1;
                  end
               end
               count_d = count_q + CNT_W'(IN_BYTES);
               if (hit_err) begin
                  state_d = StError;
               end else if (hit_done) begin
                  state_d     = StDone;
                  rem_count_d = 4'(rem_idx);
               end
            end
         end
         StDone: begin
            if (hdr_ready) begin
               state_d = StCollect;
               wipe    = 1'b1;
            end
         end
         StError: ;
         default: state_d = StCollect;
      endcase

      if (clear || wipe) begin
         count_d     = '0;
         magic_d     = '0;
         skip_d      = 1'b0;
         target_d    = '0;
         skip_size_d = '0;
         fhd_d       = '0;
         wd_d        = '0;
         did_d       = '0;
         fcs_d       = '0;
         rem_data_d  = '0;
         rem_count_d = '0;
      end
      if (clear) begin
         state_d    = StCollect;
         err_code_d = ErrNone;
      end
   end

   // State and field registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StCollect;
         count_q     <= '0;
         magic_q     <= '0;
         skip_q      <= 1'b0;
         target_q    <= '0;
         skip_size_q <= '0;
         fhd_q       <= '0;
         wd_q        <= '0;
         did_q       <= '0;
         fcs_q       <= '0;
         rem_data_q  <= '0;
         rem_count_q <= '0;
         err_code_q  <= ErrNone;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         magic_q     <= magic_d;
         skip_q      <= skip_d;
         target_q    <= target_d;
         skip_size_q <= skip_size_d;
         fhd_q       <= fhd_d;
         wd_q        <= wd_d;
         did_q       <= did_d;
         fcs_q       <= fcs_d;
         rem_data_q  <= rem_data_d;
         rem_count_q <= rem_count_d;
         err_code_q  <= err_code_d;
      end
   end

   logic hdr_fields;

   // Outputs; header fields read zero outside DONE so partial parses never leak out.
   always_comb begin
      in_ready      = (state_q == StCollect);
      hdr_valid     = (state_q == StDone);
      hdr_fields    = hdr_valid && !skip_q;
      skippable     = hdr_valid && skip_q;
      skip_size     = skippable ? skip_size_q : 32'h0;
      fhd           = hdr_fields ? fhd_q : 8'h00;
      window_desc   = hdr_fields ? wd_q : 8'h00;
      dict_id       = hdr_fields ? did_q : 32'h0;
      fcs           = 64'h0;
      if (hdr_fields) fcs = (fhd_fcs(fhd_q) == 2) ? fcs_q + 64'd256 : fcs_q;
      checksum_flag = hdr_fields && fhd_q[2];
      sizes         = hdr_fields ? {1'(fhd_wd(fhd_q)), 3'(fhd_did(fhd_q)), 4'(fhd_fcs(fhd_q))}
                                 : 8'h00;
      rem_data      = hdr_valid ? rem_data_q : '0;
      rem_count     = hdr_valid ? rem_count_q : 4'd0;
      err_valid     = (state_q == StError);
      err_code      = err_code_q;
   end

endmodule

// File: tb/tb_zstd_frame_header_parser_p.sv
// Directed bench for zstd_frame_header_parser_p: 4-byte instance with and without the
// reserved-bit check sharing one stream, plus a 2-byte instance.
module tb_zstd_frame_header_parser_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, clear, hdr_ready;
   logic in_valid4;
   logic [31:0] in_data4;
   logic b_in_valid;
   logic [15:0] b_in_data;

   logic        a_in_ready, a_hdr_valid, a_skippable, a_ck, a_err_valid;
   logic [31:0] a_skip_size, a_did, a_rdata;
   logic [7:0]  a_fhd, a_wd, a_sizes;
   logic [63:0] a_fcs;
   logic [3:0]  a_rcnt;
   logic [1:0]  a_err_code;

   logic        n_in_ready, n_hdr_valid, n_skippable, n_ck, n_err_valid;
   logic [31:0] n_skip_size, n_did, n_rdata;
   logic [7:0]  n_fhd, n_wd, n_sizes;
   logic [63:0] n_fcs;
   logic [3:0]  n_rcnt;
   logic [1:0]  n_err_code;

   logic        b_in_ready, b_hdr_valid, b_skippable, b_ck, b_err_valid;
   logic [31:0] b_skip_size, b_did;
   logic [15:0] b_rdata;
   logic [7:0]  b_fhd, b_wd, b_sizes;
   logic [63:0] b_fcs;
   logic [3:0]  b_rcnt;
   logic [1:0]  b_err_code;

   zstd_frame_header_parser_p #(.IN_BYTES(4), .CHECK_RESERVED(1'b1), .CNT_W(5)) u_dut_a (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid4), .in_ready(a_in_ready),
      .in_data(in_data4), .hdr_valid(a_hdr_valid), .hdr_ready(hdr_ready),
      .skippable(a_skippable), .skip_size(a_skip_size), .fhd(a_fhd), .window_desc(a_wd),
      .dict_id(a_did), .fcs(a_fcs), .checksum_flag(a_ck), .sizes(a_sizes),
      .rem_data(a_rdata), .rem_count(a_rcnt), .err_valid(a_err_valid), .err_code(a_err_code)
   );

   zstd_frame_header_parser_p #(.IN_BYTES(4), .CHECK_RESERVED(1'b0), .CNT_W(5)) u_dut_n (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid4), .in_ready(n_in_ready),
      .in_data(in_data4), .hdr_valid(n_hdr_valid), .hdr_ready(hdr_ready),
      .skippable(n_skippable), .skip_size(n_skip_size), .fhd(n_fhd), .window_desc(n_wd),
      .dict_id(n_did), .fcs(n_fcs), .checksum_flag(n_ck), .sizes(n_sizes),
      .rem_data(n_rdata), .rem_count(n_rcnt), .err_valid(n_err_valid), .err_code(n_err_code)
   );

   zstd_frame_header_parser_p #(.IN_BYTES(2), .CHECK_RESERVED(1'b1), .CNT_W(5)) u_dut_b (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .hdr_valid(b_hdr_valid), .hdr_ready(hdr_ready),
      .skippable(b_skippable), .skip_size(b_skip_size), .fhd(b_fhd), .window_desc(b_wd),
      .dict_id(b_did), .fcs(b_fcs), .checksum_flag(b_ck), .sizes(b_sizes),
      .rem_data(b_rdata), .rem_count(b_rcnt), .err_valid(b_err_valid), .err_code(b_err_code)
   );

   typedef struct {
      logic [127:0] data;      // byte k of the frame at bits [8k+7:8k]
      int           nbeats;
      logic [1:0]   err;
      logic         skip;
      logic [31:0]  skip_size;
      logic [7:0]   fhd;
      logic [7:0]   wd;
      logic [31:0]  did;
      logic [63:0]  fcs;
      logic         ck;
      logic [7:0]   sizes;
      logic [3:0]   rcnt;
      logic [31:0]  rdata;
   } vec_t;

   vec_t vecs [9];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic string nm(input int i, input string s);
      return $sformatf("v%0d.%s", i, s);
   endfunction

   task automatic feed4(input int i);
      for (int b = 0; b < vecs[i].nbeats; b++) begin
         if (b > 0) begin
            check(nm(i, "no_early_result"), {a_hdr_valid, a_err_valid}, 0);
            check(nm(i, "in_ready_mid"), a_in_ready, 1);
         end
         in_valid4 = 1'b1;
         in_data4  = vecs[i].data[32*b +: 32];
         @(posedge clk); #1;
      end
      in_valid4 = 1'b0;
      in_data4  = '0;
   endtask

   task automatic pulse_hdr_ready();
      hdr_ready = 1'b1;
      @(posedge clk); #1;
      hdr_ready = 1'b0;
   endtask

   task automatic run_vec(input int i);
      feed4(i);
      if (vecs[i].err != 2'd0) begin
         check(nm(i, "err_valid"), a_err_valid, 1);
         check(nm(i, "err_code"), a_err_code, vecs[i].err);
         check(nm(i, "in_ready_err"), a_in_ready, 0);
         check(nm(i, "hdr_valid_err"), a_hdr_valid, 0);
         if (vecs[i].err == 2'd2) begin
            // Same stream into the instance that ignores the reserved bit.
            check(nm(i, "norsv_hdr_valid"), n_hdr_valid, 1);
            check(nm(i, "norsv_err_valid"), n_err_valid, 0);
            check(nm(i, "norsv_fhd"), n_fhd, 8'h08);
            check(nm(i, "norsv_wd"), n_wd, 8'h5C);
            check(nm(i, "norsv_sizes"), n_sizes, 8'h80);
            check(nm(i, "norsv_rcnt"), n_rcnt, 2);
            check(nm(i, "norsv_rdata"), n_rdata, 32'h0000_2211);
         end
         in_valid4 = 1'b1;
         in_data4  = 32'hFD2FB528;
         @(posedge clk); #1;
         in_valid4 = 1'b0;
         in_data4  = '0;
         check(nm(i, "err_sticky"), {a_err_valid, a_err_code, a_in_ready}, {1'b1, vecs[i].err, 1'b0});
         clear = 1'b1;
         @(posedge clk); #1;
         clear = 1'b0;
         check(nm(i, "clr_err_valid"), a_err_valid, 0);
         check(nm(i, "clr_err_code"), a_err_code, 0);
         check(nm(i, "clr_in_ready"), a_in_ready, 1);
      end else begin
         check(nm(i, "hdr_valid"), a_hdr_valid, 1);
         check(nm(i, "err_valid"), a_err_valid, 0);
         check(nm(i, "in_ready_done"), a_in_ready, 0);
         check(nm(i, "skippable"), a_skippable, vecs[i].skip);
         check(nm(i, "skip_size"), a_skip_size, vecs[i].skip_size);
         check(nm(i, "fhd"), a_fhd, vecs[i].fhd);
         check(nm(i, "window_desc"), a_wd, vecs[i].wd);
         check(nm(i, "dict_id"), a_did, vecs[i].did);
         check(nm(i, "fcs"), a_fcs, vecs[i].fcs);
         check(nm(i, "checksum_flag"), a_ck, vecs[i].ck);
         check(nm(i, "sizes"), a_sizes, vecs[i].sizes);
         check(nm(i, "rem_count"), a_rcnt, vecs[i].rcnt);
         check(nm(i, "rem_data"), a_rdata, vecs[i].rdata);
         check(nm(i, "norsv_hdr_valid"), n_hdr_valid, 1);
         pulse_hdr_ready();
         check(nm(i, "exit_hdr_valid"), a_hdr_valid, 0);
         check(nm(i, "exit_in_ready"), a_in_ready, 1);
         check(nm(i, "exit_fcs"), a_fcs, 0);
      end
   endtask

   task automatic beat2(input logic [15:0] d);
      b_in_valid = 1'b1;
      b_in_data  = d;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      b_in_data  = '0;
   endtask

   initial begin
      reset      = 1'b1;
      clear      = 1'b0;
      hdr_ready  = 1'b0;
      in_valid4  = 1'b0;
      in_data4   = '0;
      b_in_valid = 1'b0;
      b_in_data  = '0;

      //           data                                                       nb err skp skip_size
      //           fhd    wd     did            fcs                     ck    sizes  rc rdata
      vecs[0] = '{{32'h0, 32'hAA001000, 32'h12347063, 32'hFD2FB528}, 3, 2'd0, 1'b0, 32'h0,
                  8'h63, 8'h00, 32'h00123470, 64'h110, 1'b0, 8'h42, 4'd1, 32'h0000_00AA};
      vecs[1] = '{128'h0, 1, 2'd1, 1'b0, 32'h0,
                  8'h00, 8'h00, 32'h0, 64'h0, 1'b0, 8'h00, 4'd0, 32'h0};
      vecs[2] = '{{32'h99080706, 32'h05040302, 32'h017E48C5, 32'hFD2FB528}, 4, 2'd0, 1'b0, 32'h0,
                  8'hC5, 8'h48, 32'h7E, 64'h0807060504030201, 1'b1, 8'h98, 4'd1, 32'h99};
      vecs[3] = '{{64'h0, 32'h00000010, 32'h184D2A5A}, 2, 2'd0, 1'b1, 32'd16,
                  8'h00, 8'h00, 32'h0, 64'h0, 1'b0, 8'h00, 4'd0, 32'h0};
      vecs[4] = '{{64'h0, 32'h22115C08, 32'hFD2FB528}, 2, 2'd2, 1'b0, 32'h0,
                  8'h00, 8'h00, 32'h0, 64'h0, 1'b0, 8'h00, 4'd0, 32'h0};
      vecs[5] = '{{32'h0, 32'h5A123456, 32'h78BEEFA2, 32'hFD2FB528}, 3, 2'd0, 1'b0, 32'h0,
                  8'hA2, 8'h00, 32'hBEEF, 64'h12345678, 1'b0, 8'h24, 4'd1, 32'h5A};
      vecs[6] = '{{32'h0, 32'hD3D2D1FF, 32'hFF050041, 32'hFD2FB528}, 3, 2'd0, 1'b0, 32'h0,
                  8'h41, 8'h00, 32'h05, 64'h100FF, 1'b0, 8'h92, 4'd3, 32'h00D3D2D1};
      vecs[7] = '{{64'h0, 32'h78563412, 32'h184D2A50}, 2, 2'd0, 1'b1, 32'h78563412,
                  8'h00, 8'h00, 32'h0, 64'h0, 1'b0, 8'h00, 4'd0, 32'h0};
      vecs[8] = '{{96'h0, 32'h184D2A60}, 1, 2'd1, 1'b0, 32'h0,
                  8'h00, 8'h00, 32'h0, 64'h0, 1'b0, 8'h00, 4'd0, 32'h0};

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", a_in_ready, 1);
      check("rst_hdr_valid", a_hdr_valid, 0);
      check("rst_err", {a_err_valid, a_err_code}, 0);
      check("rst_fields", {a_fcs, a_rcnt, a_sizes}, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run_vec(i);

      // Consumer stalls: result must hold and input must be refused.
      feed4(0);
      for (int c = 0; c < 5; c++) begin
         in_valid4 = 1'b1;
         in_data4  = 32'hDEADBEEF;
         @(posedge clk); #1;
         check($sformatf("hold%0d.hdr_valid", c), a_hdr_valid, 1);
         check($sformatf("hold%0d.in_ready", c), a_in_ready, 0);
         check($sformatf("hold%0d.fields", c), {a_fcs[15:0], a_did, a_rdata[7:0], a_rcnt},
               {16'h0110, 32'h00123470, 8'hAA, 4'd1});
      end
      in_valid4 = 1'b0;
      in_data4  = '0;
      pulse_hdr_ready();
      check("hold_exit", {a_hdr_valid, a_in_ready}, 2'b01);

      // Asynchronous reset in the middle of the FCS field.
      for (int b = 0; b < 3; b++) begin
         in_valid4 = 1'b1;
         in_data4  = vecs[2].data[32*b +: 32];
         @(posedge clk); #1;
      end
      in_valid4 = 1'b0;
      in_data4  = '0;
      #2 reset = 1'b1;
      #1;
      check("midrst_in_ready", a_in_ready, 1);
      check("midrst_out", {a_hdr_valid, a_err_valid, a_err_code, a_rcnt}, 0);
      check("midrst_fields", {a_fcs, a_did, a_sizes, a_fhd}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      check("postrst_in_ready", a_in_ready, 1);
      run_vec(5);

      // Two-byte instance: single-segment frame with a bubble, then a frame with leftover.
      beat2(16'hB528);
      repeat (2) @(posedge clk);
      #1;
      check("b_bubble", {b_hdr_valid, b_err_valid, b_in_ready}, 3'b001);
      beat2(16'hFD2F);
      beat2(16'h0020);
      check("b0.hdr_valid", b_hdr_valid, 1);
      check("b0.in_ready", b_in_ready, 0);
      check("b0.fhd", b_fhd, 8'h20);
      check("b0.fcs", b_fcs, 0);
      check("b0.sizes", b_sizes, 8'h01);
      check("b0.window_desc", b_wd, 0);
      check("b0.rem", {b_rcnt, b_rdata}, 0);
      pulse_hdr_ready();
      check("b0.exit", {b_hdr_valid, b_in_ready}, 2'b01);
      beat2(16'hB528);
      beat2(16'hFD2F);
      beat2(16'h0041);
      beat2(16'hFF05);
      check("b1.not_yet", b_hdr_valid, 0);
      beat2(16'hABFF);
      check("b1.hdr_valid", b_hdr_valid, 1);
      check("b1.fcs", b_fcs, 64'h100FF);
      check("b1.dict_id", b_did, 32'h05);
      check("b1.sizes", b_sizes, 8'h92);
      check("b1.rem_count", b_rcnt, 1);
      check("b1.rem_data", b_rdata, 16'h00AB);
      pulse_hdr_ready();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
